// File: rtl/clock_div_pkg.sv
// Shared types, defaults and the half-period clamp for the clock divider block.
package clock_div_pkg;

    localparam int DEF_N_CH  = 3;
    localparam int DEF_CNT_W = 27;
    localparam int DEF_DIV0  = 100000000;
    localparam int DEF_DIV1  = 50000000;
    localparam int DEF_DIV2  = 25000000;

    // Configuration controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

    // Full period -> half period; the LSB is dropped and periods below 2 become 2.
    function automatic logic [31:0] half_of(input logic [31:0] div);
        logic [31:0] h;
        h = div >> 1;
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: half-period counter, 50% duty clock, first-high tick,
// period-boundary flag and a load port for retiming the half period.
module div_channel
    import clock_div_pkg::*;
#(
    parameter int             CNT_W    = DEF_CNT_W,
    parameter logic [CNT_W-1:0] RST_HALF = 1
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             load_high,
    input  logic [CNT_W-1:0] load_half,
    output logic             clko,
    output logic             tick,
    output logic             boundary
);

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end   = (cnt == half - CNT_W'(1));
    // Last low cycle of a period: the next cycle opens a new high phase.
    assign boundary = en & at_end & ~clko;

    // Half-period register, replaced only through the load port.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            half <= RST_HALF;
        end else if (load) begin
            half <= load_half;
        end
    end

    // Counter and clock; a load restarts the phase (high after a boundary, low when idle).
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            clko <= 1'b0;
            tick <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            clko <= load_high;
            tick <= load_high;
        end else if (!en) begin
            cnt  <= '0;
            clko <= 1'b0;
            tick <= 1'b0;
        end else if (at_end) begin
            cnt  <= '0;
            clko <= ~clko;
            tick <= ~clko;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_div_ctrl.sv
// Multi-channel clock divider with a glitch-free divisor update controller.
// Handshake: a request transfers on any cycle with cfg_valid && cfg_ready;
// the requester holds cfg_ch/cfg_div stable until then, and cfg_ready is
// high only while the controller is IDLE.
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV0  = DEF_DIV0,
    parameter int DIV1  = DEF_DIV1,
    parameter int DIV2  = DEF_DIV2
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [N_CH-1:0]  en,
    output logic [N_CH-1:0]  clko,
    output logic [N_CH-1:0]  tick,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       pend_ch;
    logic [CNT_W-1:0] pend_half;
    logic [N_CH-1:0]  bnd;
    logic [N_CH-1:0]  load;
    logic             load_high;
    logic             ready_nxt;
    logic             busy_nxt;
    logic             req_ok;

    // Requests to nonexistent channels complete the handshake but change nothing.
    assign req_ok = cfg_valid && cfg_ready && (32'(cfg_ch) < N_CH);

    // State register plus registered handshake/status outputs.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_ready <= ready_nxt;
            busy      <= busy_nxt;
        end
    end

    // Single pending request register; reset drops any request in flight.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            pend_ch   <= '0;
            pend_half <= '0;
        end else if (state == IDLE && req_ok) begin
            pend_ch   <= cfg_ch;
            pend_half <= CNT_W'(half_of(32'(cfg_div)));
        end
    end

    // Next state: wait in PEND for the target's boundary or for it to be disabled.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_ok) state_nxt = PEND;
            PEND:    if (bnd[pend_ch] || !en[pend_ch]) state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: the load commits on the edge entering APPLY, so APPLY is the
    // first cycle running on the new half period and the boundary's high
    // phase is never shortened or delayed.
    always_comb begin
        load      = '0;
        load_high = bnd[pend_ch];
        for (int i = 0; i < N_CH; i++) begin
            load[i] = (state == PEND) && (pend_ch == i[1:0]) && (bnd[i] || !en[i]);
        end
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt == PEND);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        localparam int RST_DIV = (g == 0) ? DIV0 : (g == 1) ? DIV1 : DIV2;
        localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(half_of(RST_DIV));

        div_channel #(
            .CNT_W    (CNT_W),
            .RST_HALF (RST_HALF)
        ) u_ch (
            .clki      (clki),
            .rst       (rst),
            .en        (en[g]),
            .load      (load[g]),
            .load_high (load_high),
            .load_half (pend_half),
            .clko      (clko[g]),
            .tick      (tick[g]),
            .boundary  (bnd[g])
        );
    end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl with reset divisors 8/4/2.
module tb_clock_div_ctrl;

    localparam int CNT_W = 27;

    logic             clki;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [2:0]       en;
    logic [2:0]       clko;
    logic [2:0]       tick;
    logic             busy;

    int n_tests;
    int n_fail;
    int k;

    typedef struct packed {
        logic [2:0] clko;
        logic [2:0] tick;
    } vec_t;

    vec_t tbl [8];

    logic e0, e1, e2, t0, t1, t2, er, eb;

    clock_div_ctrl #(
        .N_CH  (3),
        .CNT_W (CNT_W),
        .DIV0  (8),
        .DIV1  (4),
        .DIV2  (2)
    ) dut (
        .clki      (clki),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .en        (en),
        .clko      (clko),
        .tick      (tick),
        .busy      (busy)
    );

    // Clock
    initial clki = 1'b0;
    always #5 clki = ~clki;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL k=%0d %s: got %0h expected %0h", k, name, act, exp);
        end
    endtask

    // One clock edge; samples are taken 1ns after it.
    task automatic step();
        @(posedge clki);
        #1;
        k++;
    endtask

    // Free-running reset-divisor pattern, indexed by cycles since reset release.
    task automatic run_table(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            step();
            check("table", {26'd0, clko, tick}, {26'd0, tbl[k % 8].clko, tbl[k % 8].tick});
        end
    endtask

    task automatic check_ctl(input logic exp_r, input logic exp_b);
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_r});
        check("busy", {31'd0, busy}, {31'd0, exp_b});
    endtask

    initial begin
        // phase k%8 -> {clko[2:0], tick[2:0]} for halves 4/2/1
        tbl[0] = '{3'b000, 3'b000};
        tbl[1] = '{3'b100, 3'b100};
        tbl[2] = '{3'b010, 3'b010};
        tbl[3] = '{3'b110, 3'b100};
        tbl[4] = '{3'b001, 3'b001};
        tbl[5] = '{3'b101, 3'b100};
        tbl[6] = '{3'b011, 3'b010};
        tbl[7] = '{3'b111, 3'b100};

        n_tests = 0; n_fail = 0; k = 0;
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = '0; en = 3'b111;

        // Reset state
        repeat (2) @(posedge clki);
        #1;
        check_ctl(1'b1, 1'b0);
        check("rst_out", {26'd0, clko, tick}, 32'd0);
        rst = 1'b0;
        k = 0;

        // Free-running periods 8/4/2
        run_table(1, 21);

        // ch0 -> 12 requested mid-high-phase
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 27'd12;
        for (int c = 22; c <= 40; c++) begin
            step();
            if (k == 22) cfg_valid = 1'b0;
            e0 = (k < 24) || (k >= 28 && k < 34) || (k >= 40);
            t0 = (k == 28) || (k == 40);
            e1 = (k % 4) >= 2;
            t1 = (k % 4) == 2;
            e2 = (k % 2) == 1;
            er = (k >= 29);
            eb = (k <= 27);
            check("s2_ch0", {30'd0, clko[0], tick[0]}, {30'd0, e0, t0});
            check("s2_ch12", {28'd0, clko[2:1], tick[2:1]}, {28'd0, e2, e1, e2, t1});
            check_ctl(er, eb);
        end

        // ch1 -> 1 then 7, valid held high across both requests
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 27'd1;
        for (int c = 41; c <= 52; c++) begin
            step();
            if (k == 41) cfg_div = 27'd7;
            if (k == 44) cfg_valid = 1'b0;
            case (k)
                41, 43, 45, 49, 50, 51: e1 = 1'b0;
                default:                e1 = 1'b1;
            endcase
            t1 = (k == 42) || (k == 44) || (k == 46) || (k == 52);
            e0 = (k < 46) || (k >= 52);
            t0 = (k == 52);
            e2 = (k % 2) == 1;
            er = (k == 43) || (k >= 47);
            eb = (k == 41) || (k == 44) || (k == 45);
            check("s3_ch1", {30'd0, clko[1], tick[1]}, {30'd0, e1, t1});
            check("s3_ch0", {30'd0, clko[0], tick[0]}, {30'd0, e0, t0});
            check("s3_ch2", {31'd0, clko[2]}, {31'd0, e2});
            check_ctl(er, eb);
        end

        // ch2 -> 10 while disabled, then enable
        en[2] = 1'b0;
        for (int c = 53; c <= 66; c++) begin
            step();
            if (k == 53) begin cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 27'd10; end
            if (k == 54) cfg_valid = 1'b0;
            if (k == 56) en[2] = 1'b1;
            e2 = (k >= 61) && (k <= 65);
            t2 = (k == 61);
            e0 = (k < 58) || (k >= 64);
            t0 = (k == 64);
            e1 = (((k - 52) / 3) % 2) == 0;
            t1 = ((k - 52) % 6) == 0;
            er = (k == 53) || (k >= 56);
            eb = (k == 54);
            check("s4_ch2", {30'd0, clko[2], tick[2]}, {30'd0, e2, t2});
            check("s4_ch01", {28'd0, clko[1:0], tick[1:0]}, {28'd0, e1, e0, t1, t0});
            check_ctl(er, eb);
        end

        // Reset while a ch0 request is pending
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 27'd16;
        step();
        cfg_valid = 1'b0;
        check_ctl(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_ctl(1'b1, 1'b0);
        check("async_rst", {26'd0, clko, tick}, 32'd0);
        repeat (2) @(posedge clki);
        #1;
        rst = 1'b0;
        k = 0;
        run_table(1, 16);

        // Request to channel 3 is swallowed
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 27'd2;
        step();
        check_ctl(1'b1, 1'b0);
        check("ch3_table", {26'd0, clko, tick}, {26'd0, tbl[k % 8].clko, tbl[k % 8].tick});
        cfg_valid = 1'b0;
        run_table(18, 32);
        check_ctl(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_div_ctrl.md
CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

Interface
REQ-001 SHALL have parameters: N_CH, default 3, number of divider channels; CNT_W, default 27, divisor/counter width; DIV0/DIV1/DIV2, defaults 100000000/50000000/25000000, reset divisors in clki cycles per output period.
REQ-002 SHALL have ports:
- clki  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  controller can accept a request.
- cfg_ch  input  2  target channel, 0..N_CH-1.
- cfg_div  input  CNT_W  new full period in clki cycles.
- en  input  N_CH  per-channel run enable.
- clko  output  N_CH  divided clocks, 50% duty.
- tick  output  N_CH  one-cycle pulse coincident with the first high cycle of clko.
- busy  output  1  a configuration update is pending.

Function
REQ-003 SHALL treat a request as accepted in any cycle where cfg_valid and cfg_ready are both high.
REQ-004 SHALL ignore the LSB of cfg_div and clamp values below 2 to 2, so the effective half-period is half = max(cfg_div>>1, 1).
REQ-005 SHALL silently accept and discard a request with cfg_ch >= N_CH; no state change, cfg_ready stays 1.
REQ-006 SHALL give each channel a counter cnt in 0..half-1; while en is high, cnt increments each cycle, and at cnt==half-1 it wraps to 0 and clko toggles.
REQ-007 SHALL define a period boundary as the cycle where en=1, cnt==half-1 and clko=0, so the next cycle starts a high phase.
REQ-008 SHALL assert tick[i] for exactly one cycle, registered and aligned with the first cycle clko[i] is high.
REQ-009 SHALL, while en[i]=0, hold cnt[i]=0, clko[i]=0 and tick[i]=0; after en rises, clko rises half cycles later.
REQ-010 SHALL implement the FSM IDLE -> PEND -> APPLY -> IDLE.
- IDLE: cfg_ready=1, busy=0; an accepted request latches (ch, half) into one pending register, then goes to PEND.
- PEND: cfg_ready=0, busy=1; waits for the target channel's period boundary or for en[ch]=0.
- APPLY: one cycle; loads half into the channel, with cnt=0 and clko toggling high if the boundary was taken, or cnt=0 and clko=0 if the channel is disabled; cfg_ready=0.
REQ-011 SHALL make the new divisor govern the high phase beginning right after the boundary, with no clko pulse shorter than min(old half, new half).
REQ-012 SHALL leave non-target channels undisturbed by any update; all channels run independently and concurrently.
REQ-013 SHALL keep the pending request if en[ch] falls during PEND, and apply it in the next cycle per REQ-010.
REQ-014 SHALL register all outputs; accept-to-new-period latency is at most (old period + 2) cycles.

Reset
REQ-015 SHALL, on rst assertion, immediately force: clko=0, tick=0, cnt=0, FSM=IDLE, busy=0, cfg_ready=1, and channel halves = DIVi>>1 (clamped per REQ-004).
REQ-016 SHALL discard a pending request when reset occurs mid-PEND; channels restart from reset values after rst deasserts.

Structure
REQ-017 SHALL place N_CH, CNT_W, default divisors, the FSM state enum and the half-period clamp function in shared package clock_div_pkg.
REQ-018 SHALL instantiate one sub-module, div_channel (counter, clko, tick, boundary flag, load port), N_CH times; the FSM and pending register live in clock_div_ctrl.

Verification
REQ-019 SHALL run the bench with DIV0/1/2 = 8/4/2.
REQ-020 SHALL cover these directed scenarios:
- Reset release, en=3'b111 -> clko0 period 8 (4 high/4 low), clko1 period 4, clko2 period 2; tick pulses once per period, aligned to rising clko.
- cfg ch0 div=12 mid-high-phase -> cfg_ready=0 until APPLY; current 8-period completes, next high phase is 6 cycles; ch1/ch2 unaffected.
- cfg ch1 div=1 and div=7 -> clamped to period 2 and period 6 respectively.
- cfg ch2 div=10 with en[2]=0 -> applied 2 cycles after accept; en[2] rise gives first clko2 rise 5 cycles later.
- cfg_valid held high with back-to-back requests -> second request accepted only after APPLY completes; busy high throughout PEND.
- rst pulsed during PEND -> busy=0, cfg_ready=1, ch0 reverts to period 8; cfg_ch=3 -> no effect.
